// File: rtl/fifo_umbrales_pkg.sv
// Shared defaults for the threshold FIFO: word/pointer widths and the
// power-up occupancy thresholds used by the flow-control path.
package fifo_umbrales_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 3;
    localparam int DEF_UMBRAL_AF  = 6;
    localparam int DEF_UMBRAL_AE  = 2;

endpackage : fifo_umbrales_pkg

// File: rtl/fifo_umbrales_mem_dp.sv
// DEPTH x DATA_WIDTH register file with synchronous write and registered read.
// Only the read register is reset; the storage array is not.
module mem_dp
    import fifo_umbrales_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto plain storage; every slot is
    // written before it can be read, so its power-up contents are never observed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // A read and a write to the same slot on one edge return the old word,
    // which is exactly the oldest entry when pushing and popping at full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule : mem_dp

// File: rtl/fifo_umbrales.sv
// Synchronous FIFO with programmable almost-full / almost-empty thresholds,
// registered status flags and sticky overflow/underflow latches.
module fifo_umbrales
    import fifo_umbrales_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vaciar,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    input  logic [ADDR_WIDTH:0]   umbral_af,
    input  logic [ADDR_WIDTH:0]   umbral_ae,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  empty,
    output logic                  err_overflow,
    output logic                  err_underflow,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int                DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = DEPTH[ADDR_WIDTH:0];

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  pop_ok;
    logic                  push_ok;
    logic [ADDR_WIDTH:0]   count_next;

    // Acceptance uses the pre-edge count; a push at full rides on a same-edge pop.
    always_comb begin
        pop_ok     = 1'b0;
        push_ok    = 1'b0;
        count_next = count;
        if (vaciar) begin
            count_next = '0;
        end else begin
            pop_ok     = pop && (count != '0);
            push_ok    = push && ((count < FULL_CNT) || pop_ok);
            count_next = count + (ADDR_WIDTH + 1)'(push_ok) - (ADDR_WIDTH + 1)'(pop_ok);
        end
    end

    mem_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (data_in),
        .re    (pop_ok),
        .raddr (rd_ptr),
        .rdata (data_out)
    );

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            valid_out     <= 1'b0;
            full          <= 1'b0;
            almost_full   <= 1'b0;
            almost_empty  <= 1'b1;
            empty         <= 1'b1;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (vaciar) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                if (pop_ok)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
                if (pop && !pop_ok)   err_underflow <= 1'b1;
                if (push && !push_ok) err_overflow  <= 1'b1;
            end
            count     <= count_next;
            valid_out <= pop_ok;
            // Flags follow count_next so they line up with the new count.
            full         <= (count_next == FULL_CNT);
            almost_full  <= (count_next >= umbral_af);
            almost_empty <= (count_next <= umbral_ae);
            empty        <= (count_next == '0);
        end
    end

endmodule : fifo_umbrales
